div_unit: RTL

Multi-cycle 32-bit integer divider for the pipelined CPU's execute stage. It complements the single-cycle ALU: the ALU handles add, sub, and, or and slt, while this block handles DIV/DIVU. Each operation produces a quotient (LO) and a remainder (HI) over repeated restoring shift-subtract steps. The block sits beside the ALU and holds the pipeline via `busy` while an operation is in flight.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle integer divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] part_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           unused_diff_msb;

  assign shifted = {part_i, bit_i};
  // The shifted value can reach 2*divisor-1, so the trial subtract needs WIDTH+1 bits plus a borrow.
  assign {borrow, diff} = {1'b0, shifted} - {2'b00, divisor_i};
  assign unused_diff_msb = diff[WIDTH];

  assign qbit_o = ~borrow;
  assign part_o = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// 32-bit restoring divider (DIV/DIVU), 34-cycle latency, 1 cycle for divide-by-zero.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dq_q, dq_d;
  logic [WIDTH-1:0]     part_q, part_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic                 dd_neg, ds_neg;
  logic [WIDTH-1:0]     dd_mag, ds_mag;
  logic [WIDTH-1:0]     step_part;
  logic                 step_bit;

`ifdef DIV_SIGNED_EN
  assign signed_op = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_op        = 1'b0;
`endif

  assign dd_neg = signed_op & dividend[WIDTH-1];
  assign ds_neg = signed_op & divisor[WIDTH-1];
  assign dd_mag = dd_neg ? (~dividend + 1'b1) : dividend;
  assign ds_mag = ds_neg ? (~divisor + 1'b1) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_i    (part_q),
    .bit_i     (dq_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .part_o    (step_part),
    .qbit_o    (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    part_d  = part_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (divisor == '0) begin
            quot_d = DIV_ZERO_QUOT;
            rem_d  = dividend;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dq_d    = dd_mag;
            dvsr_d  = ds_mag;
            q_neg_d = dd_neg ^ ds_neg;
            r_neg_d = dd_neg;
            part_d  = '0;
            cnt_d   = CNT_WIDTH'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          part_d = step_part;
          dq_d   = {dq_q[WIDTH-2:0], step_bit};
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          // Sign flags are always zero in an unsigned-only build, so this is a plain register stage there.
          quot_d  = q_neg_q ? (~dq_q + 1'b1) : dq_q;
          rem_d   = r_neg_q ? (~part_q + 1'b1) : part_q;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      part_q  <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      part_q  <= part_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
